uart_rx_packet: RTL and testbench

UART_RX_PACKET -- requirements
Module: uart_rx_packet

---
 rtl/uart_pkt_pkg.sv | 19 +
 rtl/uart_rx_packet_if.sv | 38 +++
 rtl/uart_rx_timeout.sv | 36 +++
 rtl/uart_rx_packet.sv | 156 +++++++++++++++
 tb/tb_uart_rx_packet.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding, error codes
// and the default start-of-packet marker.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
  } pkt_state_e;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] PKT_HEAD_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_packet_if.sv
// Byte-stream input and packet output bundle of uart_rx_packet.
// master = side that feeds bytes and consumes packets, slave = the framer.
interface uart_rx_packet_if #(
  parameter int DW = 8
);

  logic [DW-1:0] i_uart_rx_data;
  logic          i_uart_rx_valid;
  logic [DW-1:0] o_pkt_data;
  logic          o_pkt_valid;
  logic          o_pkt_last;
  logic          o_pkt_done;
  logic          o_pkt_err;
  logic [1:0]    o_err_code;

  modport master (
    output i_uart_rx_data,
    output i_uart_rx_valid,
    input  o_pkt_data,
    input  o_pkt_valid,
    input  o_pkt_last,
    input  o_pkt_done,
    input  o_pkt_err,
    input  o_err_code
  );

  modport slave (
    input  i_uart_rx_data,
    input  i_uart_rx_valid,
    output o_pkt_data,
    output o_pkt_valid,
    output o_pkt_last,
    output o_pkt_done,
    output o_pkt_err,
    output o_err_code
  );

endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle counter: pulses expire on the P_TIMEOUT_CYCLES-th consecutive
// running cycle without a clear; clear always takes priority over expiry.
module uart_rx_timeout #(
  parameter int P_TIMEOUT_CYCLES = 2000
) (
  input  logic i_u_clk,
  input  logic i_u_rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CntW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(P_TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign expire = run && !clear && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !run || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_packet.sv
// Frames a UART byte stream (HEAD, LEN, payload, CHK) into payload strobes and
// a per-packet done/error report. Define UART_PKT_TIMEOUT_EN for inter-byte timeout.
module uart_rx_packet
  import uart_pkt_pkg::*;
#(
  parameter int                           P_UART_DATA_WIDTH = 8,
  parameter logic [P_UART_DATA_WIDTH-1:0] P_PKT_HEAD        = PKT_HEAD_DEFAULT,
  parameter int                           P_PKT_MAX_LEN     = 16,
  parameter int                           P_TIMEOUT_CYCLES  = 2000
) (
  input  logic             i_u_clk,
  input  logic             i_u_rst,
  uart_rx_packet_if.slave  pkt_if
);

  localparam logic [7:0] MaxLen = 8'(P_PKT_MAX_LEN);

  pkt_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;

  logic [7:0] pkt_data_q, pkt_data_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       pkt_last_q, pkt_last_d;
  logic       pkt_done_q, pkt_done_d;
  logic       pkt_err_q, pkt_err_d;
  logic [1:0] err_code_q, err_code_d;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       len_bad;
  logic       tmo_expire;

  assign rx_valid = pkt_if.i_uart_rx_valid;
  assign rx_byte  = pkt_if.i_uart_rx_data;
  assign len_bad  = (rx_byte == 8'd0) || (rx_byte > MaxLen);

`ifdef UART_PKT_TIMEOUT_EN
  uart_rx_timeout #(
    .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)
  ) u_timeout (
    .i_u_clk(i_u_clk),
    .i_u_rst(i_u_rst),
    .clear  (rx_valid || (state_q == ST_IDLE)),
    .run    (state_q != ST_IDLE),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      chk_q       <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // A strobe always beats a coinciding timeout expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == P_PKT_HEAD) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (len_bad) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = rx_byte;
            chk_d   = rx_byte;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          cnt_d = cnt_q - 8'd1;
          chk_d = chk_q + rx_byte;
          if (cnt_q == 8'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = 1'b0;
    pkt_last_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = pkt_err_q;
    err_code_d  = err_code_q;
    if (rx_valid) begin
      case (state_q)
        ST_LEN: begin
          if (len_bad) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = 1'b1;
            err_code_d = ERR_LEN;
          end
        end
        ST_PAYLOAD: begin
          pkt_data_d  = rx_byte;
          pkt_valid_d = 1'b1;
          pkt_last_d  = (cnt_q == 8'd1);
        end
        ST_CHK: begin
          pkt_done_d = 1'b1;
          pkt_err_d  = (rx_byte != chk_q);
          err_code_d = (rx_byte == chk_q) ? ERR_OK : ERR_CHK;
        end
        default: begin
          pkt_done_d = 1'b0;
        end
      endcase
    end else if (tmo_expire) begin
      pkt_done_d = 1'b1;
      pkt_err_d  = 1'b1;
      err_code_d = ERR_TMO;
    end
  end

  assign pkt_if.o_pkt_data  = pkt_data_q;
  assign pkt_if.o_pkt_valid = pkt_valid_q;
  assign pkt_if.o_pkt_last  = pkt_last_q;
  assign pkt_if.o_pkt_done  = pkt_done_q;
  assign pkt_if.o_pkt_err   = pkt_err_q;
  assign pkt_if.o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet; the timeout scenarios run when
// UART_PKT_TIMEOUT_EN is defined, otherwise an indefinite-wait scenario runs.
module tb_uart_rx_packet;
  import uart_pkt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // payQ entries are {last, data}; doneQ entries are {err, code}
  logic [8:0] payQ[$];
  logic [2:0] doneQ[$];

  always #5 clk = ~clk;

  uart_rx_packet_if #(.DW(8)) rxIf ();

  uart_rx_packet #(
    .P_UART_DATA_WIDTH(8),
    .P_PKT_HEAD       (8'hA5),
    .P_PKT_MAX_LEN    (16),
    .P_TIMEOUT_CYCLES (50)
  ) dut (
    .i_u_clk(clk),
    .i_u_rst(rst),
    .pkt_if (rxIf)
  );

  always @(negedge clk) begin
    if (rxIf.o_pkt_valid || rxIf.o_pkt_last) payQ.push_back({rxIf.o_pkt_last, rxIf.o_pkt_data});
    if (rxIf.o_pkt_done) doneQ.push_back({rxIf.o_pkt_err, rxIf.o_err_code});
  end

  task automatic applyStimulus(input logic [7:0] b);
    rxIf.i_uart_rx_data  = b;
    rxIf.i_uart_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rxIf.i_uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    payQ.delete();
    doneQ.delete();
  endtask

  function automatic logic [31:0] allOuts();
    return {18'd0, rxIf.o_pkt_data, rxIf.o_pkt_valid, rxIf.o_pkt_last,
            rxIf.o_pkt_done, rxIf.o_pkt_err, rxIf.o_err_code};
  endfunction

  initial begin
    rxIf.i_uart_rx_data  = 8'h00;
    rxIf.i_uart_rx_valid = 1'b0;
    rst = 1'b1;
    idle(3);
    checkOutput("reset_outs", allOuts(), 32'd0);
    rst = 1'b0;
    idle(1);
    clearLog();

    // junk ahead of a header is dropped silently
    applyStimulus(8'h7E);
    applyStimulus(8'h7E);
    idle(3);
    checkOutput("junk_pay", payQ.size(), 0);
    checkOutput("junk_done", doneQ.size(), 0);

    // good 3-byte packet, back-to-back payload
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    checkOutput("lat_valid", {31'd0, rxIf.o_pkt_valid}, 32'd1);
    checkOutput("lat_data", {24'd0, rxIf.o_pkt_data}, 32'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    idle(2);
    applyStimulus(8'h69);
    idle(2);
    checkOutput("good_pay_n", payQ.size(), 3);
    checkOutput("good_pay0", {23'd0, payQ[0]}, {23'd0, 9'h011});
    checkOutput("good_pay1", {23'd0, payQ[1]}, {23'd0, 9'h022});
    checkOutput("good_pay2", {23'd0, payQ[2]}, {23'd0, 9'h133});
    checkOutput("good_done_n", doneQ.size(), 1);
    checkOutput("good_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

    // checksum mismatch
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h00);
    idle(2);
    checkOutput("bchk_pay_n", payQ.size(), 3);
    checkOutput("bchk_done_n", doneQ.size(), 1);
    checkOutput("bchk_done", {29'd0, doneQ[0]}, {29'd0, 3'b110});
    idle(5);
    checkOutput("bchk_hold", allOuts(), {18'd0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
    clearLog();

    // zero length and over-long length
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    idle(2);
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    idle(2);
    checkOutput("blen_pay_n", payQ.size(), 0);
    checkOutput("blen_done_n", doneQ.size(), 2);
    checkOutput("blen_done0", {29'd0, doneQ[0]}, {29'd0, 3'b101});
    checkOutput("blen_done1", {29'd0, doneQ[1]}, {29'd0, 3'b101});
    clearLog();

    // maximum legal length 16, payload 1..16, chk = 16 + 136 = 0x98
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
    applyStimulus(8'h98);
    idle(2);
    checkOutput("max_pay_n", payQ.size(), 16);
    checkOutput("max_pay14", {23'd0, payQ[14]}, {23'd0, 9'h00F});
    checkOutput("max_pay15", {23'd0, payQ[15]}, {23'd0, 9'h110});
    checkOutput("max_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

    // checksum wraps: 02 + FF + 02 = 0x103 -> 0x03
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'hFF);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    idle(2);
    checkOutput("wrap_pay1", {23'd0, payQ[1]}, {23'd0, 9'h102});
    checkOutput("wrap_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

    // head value inside payload is data
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'hA5);
    applyStimulus(8'hA6);
    idle(2);
    checkOutput("hpay_n", payQ.size(), 1);
    checkOutput("hpay0", {23'd0, payQ[0]}, {23'd0, 9'h1A5});
    checkOutput("hpay_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

    // reset mid-packet
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idle(1);
    clearLog();
    rst = 1'b1;
    idle(2);
    checkOutput("mrst_outs", allOuts(), 32'd0);
    rst = 1'b0;
    idle(1);
    checkOutput("mrst_nodone", doneQ.size(), 0);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h07);
    applyStimulus(8'h08);
    idle(2);
    checkOutput("mrst_pay", {23'd0, payQ[0]}, {23'd0, 9'h107});
    checkOutput("mrst_done_n", doneQ.size(), 1);
    checkOutput("mrst_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

`ifdef UART_PKT_TIMEOUT_EN
    // strobe landing on the 50th idle cycle wins over expiry
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idle(49);
    applyStimulus(8'h22);
    checkOutput("tmo_edge_none", doneQ.size(), 0);
    applyStimulus(8'h35);
    idle(2);
    checkOutput("tmo_edge_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
    clearLog();

    // 50 idle cycles expire the packet
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idle(49);
    checkOutput("tmo_early", doneQ.size(), 0);
    idle(3);
    checkOutput("tmo_done_n", doneQ.size(), 1);
    checkOutput("tmo_done", {29'd0, doneQ[0]}, {29'd0, 3'b111});
    clearLog();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h07);
    applyStimulus(8'h08);
    idle(2);
    checkOutput("tmo_after", {29'd0, doneQ[0]}, {29'd0, 3'b000});
`else
    // without the timeout the framer waits indefinitely mid-packet
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idle(300);
    checkOutput("wait_none", doneQ.size(), 0);
    applyStimulus(8'h22);
    applyStimulus(8'h35);
    idle(2);
    checkOutput("wait_done_n", doneQ.size(), 1);
    checkOutput("wait_done", {29'd0, doneQ[0]}, {29'd0, 3'b000});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
